// File: rtl/sram_port_arbiter.sv
// Two-channel (read/write) arbiter in front of a single-port SRAM.
// Fair alternation on ties, address range checking, and a fixed read latency.
module sram_port_arbiter #(
   parameter int unsigned data_width      = 16,
   parameter int unsigned sram_addr_width = 12,
   parameter int unsigned sram_capacity   = 4096,
   parameter int unsigned read_latency    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_sram_read,
   input  logic [sram_addr_width-1:0] req_sram_read_addr,
   input  logic                       req_sram_write,
   input  logic [sram_addr_width-1:0] req_sram_write_addr,
   input  logic [data_width-1:0]      data_to_sram,
   output logic [data_width-1:0]      data_from_sram,
   output logic                       sram_read_ready,
   output logic                       sram_write_ready,
   output logic                       sram_read_invalid,
   output logic                       sram_write_invalid,
   output logic                       sram_en,
   output logic                       sram_we,
   output logic [sram_addr_width-1:0] sram_addr,
   output logic [data_width-1:0]      sram_wdata,
   input  logic [data_width-1:0]      sram_rdata
);

   localparam int unsigned CmpW = (sram_addr_width > 32) ? sram_addr_width : 32;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StReadWait = 2'd1;
   localparam logic [1:0] StWrite    = 2'd2;
   localparam logic [1:0] StDone     = 2'd3;

   logic [1:0]                 state_q, state_d;
   logic                       last_wr_q, last_wr_d;
   logic [2:0]                 cnt_q, cnt_d;
   logic                       inv_q, inv_d;
   logic [data_width-1:0]      dout_q, dout_d;
   logic                       rd_rdy_q, rd_rdy_d;
   logic                       wr_rdy_q, wr_rdy_d;
   logic                       rd_inv_q, rd_inv_d;
   logic                       wr_inv_q, wr_inv_d;
   logic                       en_q, en_d;
   logic                       we_q, we_d;
   logic [sram_addr_width-1:0] addr_q, addr_d;
   logic [data_width-1:0]      wdata_q, wdata_d;

   logic grant_rd, grant_wr;
   logic rd_ok, wr_ok;

   // Unsigned range check, zero-extended so narrow and wide address buses compare alike.
   always_comb begin
      rd_ok = CmpW'(req_sram_read_addr) < CmpW'(sram_capacity);
      wr_ok = CmpW'(req_sram_write_addr) < CmpW'(sram_capacity);
   end

   // Grant decision; on a tie the channel not granted last time wins.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (state_q == StIdle) begin
         grant_rd = req_sram_read && (!req_sram_write || last_wr_q);
         grant_wr = req_sram_write && !grant_rd;
      end
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      cnt_d     = cnt_q;
      inv_d     = inv_q;
      dout_d    = dout_q;
      rd_rdy_d  = 1'b0;
      wr_rdy_d  = 1'b0;
      rd_inv_d  = 1'b0;
      wr_inv_d  = 1'b0;
      en_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      case (state_q)
         StIdle: begin
            if (grant_rd) begin
               last_wr_d = 1'b0;
               inv_d     = !rd_ok;
               state_d   = StReadWait;
               if (rd_ok) begin
                  en_d   = 1'b1;
                  addr_d = req_sram_read_addr;
                  cnt_d  = 3'(read_latency);
               end else begin
                  // Rejected read: terminate READ_WAIT on the very next edge.
                  cnt_d = 3'd0;
               end
            end else if (grant_wr) begin
               last_wr_d = 1'b1;
               inv_d     = !wr_ok;
               state_d   = StWrite;
               if (wr_ok) begin
                  en_d    = 1'b1;
                  we_d    = 1'b1;
                  addr_d  = req_sram_write_addr;
                  wdata_d = data_to_sram;
               end
            end
         end
         StReadWait: begin
            if (cnt_q == 3'd0) begin
               if (inv_q) begin
                  rd_inv_d = 1'b1;
               end else begin
                  rd_rdy_d = 1'b1;
                  dout_d   = sram_rdata;
               end
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StWrite: begin
            if (inv_q) begin
               wr_inv_d = 1'b1;
            end else begin
               wr_rdy_d = 1'b1;
            end
            state_d = StDone;
         end
         default: begin
            // DONE: ignore requests for one cycle so a dropped request is never re-granted.
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         last_wr_q <= 1'b1;
         cnt_q     <= '0;
         inv_q     <= 1'b0;
         dout_q    <= '0;
         rd_rdy_q  <= 1'b0;
         wr_rdy_q  <= 1'b0;
         rd_inv_q  <= 1'b0;
         wr_inv_q  <= 1'b0;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         cnt_q     <= cnt_d;
         inv_q     <= inv_d;
         dout_q    <= dout_d;
         rd_rdy_q  <= rd_rdy_d;
         wr_rdy_q  <= wr_rdy_d;
         rd_inv_q  <= rd_inv_d;
         wr_inv_q  <= wr_inv_d;
         en_q      <= en_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Drive ports straight from flops.
   always_comb begin
      data_from_sram     = dout_q;
      sram_read_ready    = rd_rdy_q;
      sram_write_ready   = wr_rdy_q;
      sram_read_invalid  = rd_inv_q;
      sram_write_invalid = wr_inv_q;
      sram_en            = en_q;
      sram_we            = we_q;
      sram_addr          = addr_q;
      sram_wdata         = wdata_q;
   end

endmodule
